// File: rtl/soc_monitor_if.sv
// soc_monitor_if: core data port as seen by the monitor, requests in and gated RAM strobes out
interface soc_monitor_if;
  logic        req_r;
  logic [3:0]  req_w;
  logic [31:0] req_addr;
  logic        ram_r;
  logic [3:0]  ram_w;
  modport master (output req_r, req_w, req_addr, input ram_r, ram_w);
  modport slave (input req_r, req_w, req_addr, output ram_r, ram_w);
endinterface

// File: rtl/soc_monitor.sv
// soc_monitor: run-control and memory-protection monitor that gates RAM strobes, halts on the first fault and records it
module soc_monitor #(
  parameter int unsigned RAM_WORDS    = 4194304,
  parameter bit          SP_CHECK     = 1'b1,
  parameter bit          ALIGN_CHECK  = 1'b1,
  parameter int unsigned STUCK_CYCLES = 0,
  parameter int unsigned CYCLE_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               brk,
  input  logic               resume,
  input  logic [29:0]        pc,
  input  logic [31:0]        sp,
  soc_monitor_if.slave       bus,
  output logic               halt,
  output logic [2:0]         fault_code,
  output logic [31:0]        fault_pc,
  output logic [31:0]        fault_addr,
  output logic [CYCLE_W-1:0] cycles
);
  localparam logic [32:0] RAM_TOP = 33'(RAM_WORDS) * 33'd4;
  localparam int SW = STUCK_CYCLES > 0 ? $clog2(STUCK_CYCLES + 1) : 1;
  typedef enum logic {RUN, HALTED} state_t;
  typedef enum logic [2:0] {NONE, BRK, RAM_RANGE, SP_RANGE, MISALIGN, STUCK} code_t;
  state_t state;
  logic brk_q, pc_v, same_pc, acc, legal_w, range_e, sp_e, mis_e, stuck_e, brk_e, any_e, pass;
  logic [29:0] pc_q;
  logic [SW-1:0] stuck_cnt;
  logic [1:0] a;
  code_t code;
  logic [31:0] addr;
  always_comb begin
    a = bus.req_addr[1:0];
    acc = bus.req_r | (|bus.req_w);
    case (bus.req_w)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: legal_w = bus.req_w[a];
      4'b0011, 4'b1100: legal_w = !a[0] && bus.req_w[{a[1], 1'b0}];
      4'b1111: legal_w = a == 2'd0;
      default: legal_w = 1'b0;
    endcase
    range_e = acc && {1'b0, bus.req_addr} >= RAM_TOP;
    sp_e = SP_CHECK && {1'b0, sp} > RAM_TOP;
    mis_e = ALIGN_CHECK && (|bus.req_w) && !legal_w;
    // pc_v masks the first cycle after reset, which has no meaningful previous PC
    same_pc = pc_v && pc == pc_q;
    stuck_e = STUCK_CYCLES != 0 && same_pc && 32'(stuck_cnt) + 32'd1 >= STUCK_CYCLES;
    brk_e = brk && !brk_q;
    any_e = state == RUN && (range_e || sp_e || mis_e || stuck_e || brk_e);
    code = range_e ? RAM_RANGE : sp_e ? SP_RANGE : mis_e ? MISALIGN : stuck_e ? STUCK : BRK;
    addr = code == SP_RANGE ? sp : (code == RAM_RANGE || code == MISALIGN) ? bus.req_addr : 32'd0;
    pass = state == RUN && !range_e && !mis_e;
    bus.ram_r = pass && bus.req_r;
    bus.ram_w = pass ? bus.req_w : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fault_code <= NONE;
      fault_pc <= '0;
      fault_addr <= '0;
      cycles <= '0;
      stuck_cnt <= '0;
      brk_q <= 1'b1;
      pc_q <= '0;
      pc_v <= 1'b0;
    end else begin
      brk_q <= brk;
      pc_q <= pc;
      pc_v <= 1'b1;
      if (state == RUN) begin
        cycles <= &cycles ? cycles : cycles + 1'b1;
        stuck_cnt <= (STUCK_CYCLES != 0 && same_pc) ? stuck_cnt + 1'b1 : '0;
        if (any_e) begin
          state <= HALTED;
          fault_code <= code;
          fault_pc <= {pc, 2'b00};
          fault_addr <= addr;
        end
      end else begin
        stuck_cnt <= '0;
        if (resume && fault_code == BRK) begin
          state <= RUN;
          fault_code <= NONE;
        end
      end
    end
  end
  assign halt = state == HALTED;
endmodule

// File: tb/tb_soc_monitor.sv
// tb_soc_monitor: directed plus randomized checks of two soc_monitor configurations against a behavioural model
module tb_soc_monitor;
  logic clk = 1'b0, rst = 1'b1, brk = 1'b0, resume = 1'b0, req_r = 1'b0, hold_pc = 1'b0, armed = 1'b0;
  logic [3:0] req_w = 4'b0;
  logic [31:0] req_addr = 32'h0, sp = 32'h8000;
  logic [29:0] pc = 30'h40;
  logic halt_a, halt_b;
  logic [2:0] code_a, code_b;
  logic [31:0] fpc_a, fpc_b, faddr_a, faddr_b, cyc_a;
  logic [3:0] cyc_b;
  int checks = 0, errors = 0;

  soc_monitor_if ifa();
  soc_monitor_if ifb();
  assign ifa.req_r = req_r;
  assign ifa.req_w = req_w;
  assign ifa.req_addr = req_addr;
  assign ifb.req_r = req_r;
  assign ifb.req_w = req_w;
  assign ifb.req_addr = req_addr;

  always #5 clk = ~clk;

  soc_monitor dut_a (
    .clk(clk), .rst(rst), .brk(brk), .resume(resume), .pc(pc), .sp(sp), .bus(ifa.slave),
    .halt(halt_a), .fault_code(code_a), .fault_pc(fpc_a), .fault_addr(faddr_a), .cycles(cyc_a)
  );
  soc_monitor #(.RAM_WORDS(1024), .SP_CHECK(1'b0), .STUCK_CYCLES(8), .CYCLE_W(4)) dut_b (
    .clk(clk), .rst(rst), .brk(brk), .resume(resume), .pc(pc), .sp(sp), .bus(ifb.slave),
    .halt(halt_b), .fault_code(code_b), .fault_pc(fpc_b), .fault_addr(faddr_b), .cycles(cyc_b)
  );

  longint top[2] = '{64'h0100_0000, 64'd4096};
  bit spc[2] = '{1'b1, 1'b0};
  int stk[2] = '{0, 8};
  longint cmax[2] = '{64'hFFFF_FFFF, 64'd15};
  bit m_halt[2];
  int m_code[2], m_scnt[2];
  logic [31:0] m_fpc[2], m_faddr[2];
  longint m_cyc[2];
  bit m_brk_prev = 1'b1, m_pv = 1'b0;
  logic [29:0] m_pc_prev = '0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A store is legal when it covers 1, 2 or 4 contiguous bytes, naturally aligned, starting at the addressed byte
  function automatic bit store_ok(logic [3:0] w, logic [1:0] a);
    int n = $countones(w);
    if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
    return (int'(a) % n == 0) && (int'(w) == (((1 << n) - 1) << a));
  endfunction

  function automatic bit bad_access(int d);
    bit acc = req_r || req_w != 0;
    return (acc && {32'd0, req_addr} >= top[d]) || (req_w != 0 && !store_ok(req_w, req_addr[1:0]));
  endfunction

  function automatic int ev_code(int d);
    bit acc = req_r || req_w != 0;
    if (m_halt[d]) return 0;
    if (acc && {32'd0, req_addr} >= top[d]) return 2;
    if (spc[d] && {32'd0, sp} > top[d]) return 3;
    if (req_w != 0 && !store_ok(req_w, req_addr[1:0])) return 4;
    if (stk[d] > 0 && m_pv && pc == m_pc_prev && m_scnt[d] + 1 >= stk[d]) return 5;
    if (brk && !m_brk_prev) return 1;
    return 0;
  endfunction

  task automatic check_dut(int d);
    bit ok = !m_halt[d] && !bad_access(d);
    string n = d == 0 ? "a" : "b";
    logic [63:0] o[7];
    if (d == 0) o = '{64'(halt_a), 64'(code_a), 64'(fpc_a), 64'(faddr_a), 64'(cyc_a), 64'(ifa.ram_r), 64'(ifa.ram_w)};
    else o = '{64'(halt_b), 64'(code_b), 64'(fpc_b), 64'(faddr_b), 64'(cyc_b), 64'(ifb.ram_r), 64'(ifb.ram_w)};
    chk({n, "_halt"}, o[0], 64'(m_halt[d]));
    chk({n, "_code"}, o[1], 64'(m_code[d]));
    chk({n, "_fault_pc"}, o[2], 64'(m_fpc[d]));
    chk({n, "_fault_addr"}, o[3], 64'(m_faddr[d]));
    chk({n, "_cycles"}, o[4], 64'(m_cyc[d]));
    chk({n, "_ram_r"}, o[5], 64'(ok && req_r));
    chk({n, "_ram_w"}, o[6], ok ? 64'(req_w) : 64'd0);
  endtask

  task automatic model_edge(int d, int ev);
    if (rst) begin
      m_halt[d] = 1'b0;
      m_code[d] = 0;
      m_fpc[d] = '0;
      m_faddr[d] = '0;
      m_cyc[d] = 0;
      m_scnt[d] = 0;
    end else if (!m_halt[d]) begin
      if (m_cyc[d] < cmax[d]) m_cyc[d]++;
      m_scnt[d] = (m_pv && pc == m_pc_prev) ? m_scnt[d] + 1 : 0;
      if (ev != 0) begin
        m_halt[d] = 1'b1;
        m_code[d] = ev;
        m_fpc[d] = {pc, 2'b00};
        m_faddr[d] = ev == 3 ? sp : (ev == 2 || ev == 4) ? req_addr : 32'd0;
      end
    end else begin
      m_scnt[d] = 0;
      if (resume && m_code[d] == 1) begin
        m_halt[d] = 1'b0;
        m_code[d] = 0;
      end
    end
  endtask

  task automatic step();
    int ev[2];
    if (!hold_pc) pc = pc + 30'd1;
    #1;
    for (int d = 0; d < 2; d++) begin
      ev[d] = ev_code(d);
      if (armed) check_dut(d);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, ev[d]);
    m_brk_prev = rst ? 1'b1 : brk;
    m_pv = !rst;
    m_pc_prev = pc;
    @(negedge clk);
  endtask

  task automatic idle();
    req_r = 1'b0;
    req_w = 4'b0;
    req_addr = 32'h100;
    brk = 1'b0;
    resume = 1'b0;
    sp = 32'h8000;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    armed = 1'b1;
    chk("rst_halt", 64'(halt_a), 64'd0);
    chk("rst_code", 64'(code_a), 64'd0);
    chk("rst_cycles", 64'(cyc_a), 64'd0);
    chk("rst_fault_addr", 64'(faddr_a), 64'd0);

    req_w = 4'b1111;
    req_addr = 32'h0100_0000;
    #1 chk("range_gate", 64'(ifa.ram_w), 64'd0);
    step();
    chk("range_halt", 64'(halt_a), 64'd1);
    chk("range_code", 64'(code_a), 64'd2);
    chk("range_addr", 64'(faddr_a), 64'h0100_0000);

    do_reset();
    sp = 32'h0100_0000;
    step();
    chk("sp_top_ok", 64'(halt_a), 64'd0);
    sp = 32'h0100_0004;
    step();
    chk("sp_code", 64'(code_a), 64'd3);
    chk("sp_addr", 64'(faddr_a), 64'h0100_0004);
    chk("sp_disabled", 64'(halt_b), 64'd0);

    do_reset();
    req_w = 4'b1111;
    req_addr = 32'h102;
    step();
    chk("mis_word", 64'(code_a), 64'd4);
    do_reset();
    req_w = 4'b1100;
    req_addr = 32'h102;
    #1 chk("half_pass", 64'(ifa.ram_w), 64'hC);
    step();
    chk("half_nohalt", 64'(halt_a), 64'd0);
    req_w = 4'b0101;
    req_addr = 32'h100;
    step();
    chk("mis_0101", 64'(code_a), 64'd4);

    do_reset();
    for (int i = 0; i < 100; i++) step();
    brk = 1'b1;
    step();
    chk("brk_code", 64'(code_a), 64'd1);
    chk("brk_cycles", 64'(cyc_a), 64'd101);
    chk("cyc_sat", 64'(cyc_b), 64'd15);
    step();
    step();
    chk("brk_frozen", 64'(cyc_a), 64'd101);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume_halt", 64'(halt_a), 64'd0);
    chk("resume_code", 64'(code_a), 64'd0);
    for (int i = 0; i < 3; i++) step();
    chk("brk_held", 64'(halt_a), 64'd0);
    brk = 1'b0;
    step();
    brk = 1'b1;
    step();
    chk("brk_rearm", 64'(halt_a), 64'd1);

    hold_pc = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    chk("stuck_7", 64'(halt_b), 64'd0);
    step();
    chk("stuck_8", 64'(code_b), 64'd5);
    do_reset();
    for (int i = 0; i < 7; i++) step();
    pc = pc + 30'd4;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("stuck_break", 64'(halt_b), 64'd0);
    hold_pc = 1'b0;

    do_reset();
    step();
    brk = 1'b1;
    req_w = 4'b1111;
    req_addr = 32'h0100_0000;
    step();
    chk("prio_code", 64'(code_a), 64'd2);
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_halt", 64'(halt_a), 64'd0);
    chk("mid_rst_code", 64'(code_a), 64'd0);
    chk("mid_rst_pc", 64'(fpc_a), 64'd0);

    hold_pc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = ((m_halt[0] && m_code[0] != 1) || (m_halt[1] && m_code[1] != 1)) ? $urandom_range(3) == 0 : $urandom_range(80) == 0;
      resume = $urandom_range(3) == 0;
      if ($urandom_range(5) == 0) brk = ~brk;
      if ($urandom_range(11) == 0) pc = 30'($urandom);
      req_r = $urandom_range(3) == 0;
      req_w = $urandom_range(1) == 0 ? 4'b0 : 4'($urandom);
      case ($urandom_range(3))
        0: req_addr = $urandom_range(4095);
        1: req_addr = $urandom_range(32'h00FF_FFFF, 4096);
        2: req_addr = 32'h00FF_FFFC + $urandom_range(7);
        default: req_addr = $urandom;
      endcase
      sp = $urandom_range(7) == 0 ? 32'h00FF_FFFC + 32'($urandom_range(2)) * 4 : 32'h8000;
      step();
    end
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/soc_monitor.md
# soc_monitor

Synthesizable run-control and memory-protection monitor between the core's data port and RAM, parametrised over memory sizes and check set. It gates RAM strobes, detects breakpoints, RAM-range, stack-pointer, misaligned-store and stuck-PC faults, and records the first event with its PC and address. It freezes the core through `halt` and keeps a saturating cycle counter, replacing simulation-only checks with hardware usable on FPGA.

## Interface
Parameters:
- `RAM_WORDS`, 4194304, RAM depth in 32-bit words; legal byte addresses are 0 .. RAM_WORDS*4-1.
- `SP_CHECK`, 1, enables the stack-pointer range check.
- `ALIGN_CHECK`, 1, enables the misaligned-store check.
- `STUCK_CYCLES`, 0, number of consecutive unchanged-PC cycles that raises STUCK; 0 disables the check.
- `CYCLE_W`, 32, cycle counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `brk`  in  1  core breakpoint level; fires on its rising edge.
- `resume`  in  1  one-cycle pulse that leaves HALTED after a BRK only.
- `pc`  in  30  core word PC.
- `sp`  in  32  core x2 value.
- `req_r`  in  1  core RAM read request.
- `req_w`  in  4  core RAM byte write strobes.
- `req_addr`  in  32  core RAM byte address.
- `ram_r`  out  1  gated read to RAM.
- `ram_w`  out  4  gated write strobes to RAM.
- `halt`  out  1  core stall; high while HALTED.
- `fault_code`  out  3  0 NONE, 1 BRK, 2 RAM_RANGE, 3 SP_RANGE, 4 MISALIGN, 5 STUCK.
- `fault_pc`  out  32  byte PC ({pc,2'b00}) at the event.
- `fault_addr`  out  32  `req_addr` at the event (`sp` for SP_RANGE, 0 for BRK/STUCK).
- `cycles`  out  CYCLE_W  cycles spent in RUN.

## Operation
- States: RUN, HALTED. After reset: RUN.
- Event detection is combinational in RUN, evaluated every cycle:
  - RAM_RANGE: (`req_r` or `req_w` != 0) and `req_addr` >= RAM_WORDS*4. Compare at 33 bits; no overflow.
  - SP_RANGE: `SP_CHECK` and `sp` > RAM_WORDS*4. `sp` equal to the top of RAM is legal.
  - MISALIGN: `ALIGN_CHECK` and `req_w` != 0, where the strobe is not 0001/0010/0100/1000, 0011 with addr[1:0]=0, 0011 shifted per addr[1], or 1111 with addr[1:0]=0. Strobes must match addr[1:0]: a byte store at addr[1:0]=k uses bit k, a half store at addr[1]=h uses bits 2h+1:2h. Any other pattern, including 0101, is MISALIGN.
  - STUCK: a counter counts consecutive cycles with `pc` equal to the previous cycle's `pc`. It fires when the count reaches `STUCK_CYCLES`. It clears on any PC change and in HALTED.
  - BRK: `brk` high and `brk_q` low.
- Priority when several events occur in one cycle: RAM_RANGE > SP_RANGE > MISALIGN > STUCK > BRK.
- On any event in RUN:
  - latch `fault_code`, `fault_pc`, `fault_addr`;
  - go to HALTED.
- Gating: in the event cycle, a RAM_RANGE or MISALIGN access is suppressed combinationally (`ram_r`=0, `ram_w`=0). Legal accesses pass through unchanged. In HALTED, `ram_r`=0 and `ram_w`=0.
- In HALTED:
  - `resume` with `fault_code`=BRK returns to RUN and clears `fault_code` to 0. `fault_pc` and `fault_addr` hold.
  - `resume` with any other code is ignored; only `rst` clears a fault.
  - New events are ignored.
- `cycles` increments in every RUN cycle (including the event cycle) and saturates at all-ones.
- Reset values: `halt`=0, `fault_code`=0, `fault_pc`=0, `fault_addr`=0, `cycles`=0, stuck counter=0, `brk_q`=1 (a `brk` held through reset does not fire).
- `rst` has priority over everything. Asserted in HALTED, it returns to RUN next cycle with all state at reset values.

## Timing
- Detection and gating: 0 cycles (same cycle as the request).
- `halt`, `fault_*`: valid from the cycle after the event edge, i.e. 1-cycle latency.
- `brk_q` <= `brk` every cycle. A `brk` held high fires once. It re-arms after one low cycle.
- `resume` sampled at edge N: `halt` low in cycle N+1. If `brk` is still high, no re-fire until it drops and rises again.
- `resume` and an event in the same cycle while in RUN: the event wins and `resume` is ignored.

## Test plan
- Word store at `req_addr`=RAM_WORDS*4 with `req_w`=1111 → `ram_w`=0000 that cycle, next cycle `halt`=1, `fault_code`=2, `fault_addr`=0x01000000 (default RAM_WORDS).
- `sp`=0x01000000, then `sp`=0x01000004 → no fault, then `fault_code`=3 and `fault_addr`=0x01000004. Repeat with SP_CHECK=0 → no fault.
- Stores: 1111@addr 0x...2 → MISALIGN. 1100@0x...2 → pass-through. 0101@0x...0 → MISALIGN.
- `brk` rises with `cycles`=100 → `fault_code`=1, `cycles` frozen at 101. `resume` → RUN, `fault_code`=0, no re-fire with `brk` held high.
- STUCK_CYCLES=8, `pc` constant → fault on the 8th equal-PC cycle. A PC change at cycle 7 → no fault.
- Same-cycle out-of-range store and `brk` rise → `fault_code`=2. `rst` mid-HALTED → all outputs 0, RUN. CYCLE_W=4 → `cycles` saturates at 15.
